bcd_alu_seq: RTL and testbench

//  Parametrised sign-magnitude BCD calculator core for the keypad calculator datapath. Accepts

---
 rtl/bcd_alu_seq_if.sv | 31 +++
 rtl/bcd_alu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_bcd_alu_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_alu_seq_if : keypad strobes in, display/status out for bcd_alu_seq      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface bcd_alu_seq_if #(
   parameter int DIGITS = 10
);
   logic                  clear;
   logic                  digit_valid;
   logic [3:0]            digit;
   logic                  op_valid;
   logic [1:0]            op;
   logic [4*DIGITS-1:0]   aux;
   logic                  sgn_aux;
   logic                  full_aux;
   logic                  busy;
   logic                  done;
   logic                  overflow;

   modport master (
      output clear, digit_valid, digit, op_valid, op,
      input  aux, sgn_aux, full_aux, busy, done, overflow
   );

   modport slave (
      input  clear, digit_valid, digit, op_valid, op,
      output aux, sgn_aux, full_aux, busy, done, overflow
   );
endinterface
`default_nettype wire

// File: rtl/bcd_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_alu_seq : sign-magnitude BCD calculator core, one digit per clock       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module bcd_alu_seq #(
   parameter int DIGITS = 10
) (
   input  wire logic     clk,
   input  wire logic     rst,
   bcd_alu_seq_if.slave  bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   localparam logic [1:0] c_OP_NONE = 2'b00;
   localparam logic [1:0] c_OP_SUB  = 2'b10;
   localparam logic [1:0] c_OP_EQ   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_NEG  = 3'd2,
      S_DONE = 3'd3,
      S_LOCK = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    aux_q, aux_d;
   logic            sgn_aux_q, sgn_aux_d;
   logic            full_q, full_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;
   logic [W-1:0]    acc_q, acc_d;
   logic            sgn_acc_q, sgn_acc_d;
   logic            pend_sub_q, pend_sub_d;
   logic            chain_q, chain_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [W-1:0]    opb_q, opb_d;
   logic [W-5:0]    res_q, res_d;
   logic            carry_q, carry_d;
   logic            sub_q, sub_d;

   // Shared digit adder: CALC adds a + (b or 9-b); NEG adds (9-a) + 0 + 1 for the 10s complement.
   logic [3:0]      w_a, w_b, w_dig;
   logic [4:0]      w_sum;
   logic            w_cout;
   logic [W-1:0]    w_res;
   logic            w_last;
   logic            w_sgn;

   assign w_a    = (state_q == S_NEG) ? (4'd9 - opa_q[3:0]) : opa_q[3:0];
   assign w_b    = (state_q == S_CALC && sub_q) ? (4'd9 - opb_q[3:0]) : opb_q[3:0];
   assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {4'b0000, carry_q};
   assign w_cout = (w_sum > 5'd9);
   assign w_dig  = w_cout ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
   assign w_res  = {w_dig, res_q};
   assign w_last = (idx_q == CW'(DIGITS - 1));
   assign w_sgn  = (w_res == '0) ? 1'b0 :
                   ((state_q == S_NEG) ? ~sgn_acc_q : sgn_acc_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         aux_q      <= '0;
         sgn_aux_q  <= 1'b0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         acc_q      <= '0;
         sgn_acc_q  <= 1'b0;
         pend_sub_q <= 1'b0;
         chain_q    <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         res_q      <= '0;
         carry_q    <= 1'b0;
         sub_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         aux_q      <= aux_d;
         sgn_aux_q  <= sgn_aux_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         acc_q      <= acc_d;
         sgn_acc_q  <= sgn_acc_d;
         pend_sub_q <= pend_sub_d;
         chain_q    <= chain_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         res_q      <= res_d;
         carry_q    <= carry_d;
         sub_q      <= sub_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      aux_d      = aux_q;
      sgn_aux_d  = sgn_aux_q;
      full_d     = full_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      acc_d      = acc_q;
      sgn_acc_d  = sgn_acc_q;
      pend_sub_d = pend_sub_q;
      chain_d    = chain_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      res_d      = res_q;
      carry_d    = carry_q;
      sub_d      = sub_q;

      if (bus.clear) begin
         state_d    = S_IDLE;
         aux_d      = '0;
         sgn_aux_d  = 1'b0;
         full_d     = 1'b0;
         ovf_d      = 1'b0;
         acc_d      = '0;
         sgn_acc_d  = 1'b0;
         pend_sub_d = 1'b0;
         chain_d    = 1'b0;
         cnt_d      = '0;
         idx_d      = '0;
         opa_d      = '0;
         opb_d      = '0;
         res_d      = '0;
         carry_d    = 1'b0;
         sub_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.digit_valid) begin
                  if (bus.digit <= 4'd9) begin
                     if (chain_q) begin
                        acc_d      = '0;
                        sgn_acc_d  = 1'b0;
                        pend_sub_d = 1'b0;
                        chain_d    = 1'b0;
                     end
                     if (cnt_q == '0) begin
                        aux_d     = {{(W-4){1'b0}}, bus.digit};
                        sgn_aux_d = 1'b0;
                        cnt_d     = CW'(1);
                     end else if (cnt_q < CW'(DIGITS)) begin
                        aux_d  = {aux_q[W-5:0], bus.digit};
                        cnt_d  = cnt_q + CW'(1);
                        full_d = (cnt_q == CW'(DIGITS - 1));
                     end
                  end
               end else if (bus.op_valid && bus.op != c_OP_NONE) begin
                  if (cnt_q == '0) begin
                     // No operand keyed since the last op: only the pending op may change.
                     if (bus.op != c_OP_EQ) begin
                        pend_sub_d = (bus.op == c_OP_SUB);
                        chain_d    = 1'b0;
                     end
                  end else begin
                     sub_d      = sgn_acc_q ^ pend_sub_q;
                     carry_d    = sgn_acc_q ^ pend_sub_q;
                     opa_d      = acc_q;
                     opb_d      = aux_q;
                     res_d      = '0;
                     idx_d      = '0;
                     pend_sub_d = (bus.op == c_OP_SUB);
                     chain_d    = (bus.op == c_OP_EQ);
                     state_d    = S_CALC;
                  end
               end
            end

            S_CALC, S_NEG: begin
               opa_d   = opa_q >> 4;
               opb_d   = opb_q >> 4;
               res_d   = w_res[W-1:4];
               carry_d = w_cout;
               idx_d   = idx_q + CW'(1);
               if (w_last) begin
                  if (state_q == S_CALC && !sub_q && w_cout) begin
                     aux_d     = {{(W-8){1'b0}}, 8'hEE};
                     sgn_aux_d = 1'b0;
                     ovf_d     = 1'b1;
                     done_d    = 1'b1;
                     cnt_d     = '0;
                     full_d    = 1'b0;
                     state_d   = S_LOCK;
                  end else if (state_q == S_CALC && sub_q && !w_cout) begin
                     // |acc| < |aux|: the sum is the 10s complement of the true magnitude.
                     opa_d   = w_res;
                     opb_d   = '0;
                     res_d   = '0;
                     carry_d = 1'b1;
                     idx_d   = '0;
                     state_d = S_NEG;
                  end else begin
                     aux_d     = w_res;
                     sgn_aux_d = w_sgn;
                     acc_d     = w_res;
                     sgn_acc_d = w_sgn;
                     done_d    = 1'b1;
                     cnt_d     = '0;
                     full_d    = 1'b0;
                     state_d   = S_DONE;
                  end
               end
            end

            S_DONE:  state_d = S_IDLE;
            S_LOCK:  state_d = S_LOCK;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.aux      = aux_q;
   assign bus.sgn_aux  = sgn_aux_q;
   assign bus.full_aux = full_q;
   assign bus.busy     = (state_q == S_CALC) || (state_q == S_NEG);
   assign bus.done     = done_q;
   assign bus.overflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bcd_alu_seq : directed keypad sequences on 4- and 10-digit instances     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_bcd_alu_seq;
   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   bcd_alu_seq_if #(.DIGITS(4))  i4 ();
   bcd_alu_seq_if #(.DIGITS(10)) i10 ();

   bcd_alu_seq #(.DIGITS(4))  dut4  (.clk(clk), .rst(rst), .bus(i4));
   bcd_alu_seq #(.DIGITS(10)) dut10 (.clk(clk), .rst(rst), .bus(i10));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] aux_of(input bit big);
      return big ? 64'(i10.aux) : 64'(i4.aux);
   endfunction

   // {sgn_aux, full_aux, busy, done, overflow}
   function automatic logic [4:0] status_of(input bit big);
      return big ? {i10.sgn_aux, i10.full_aux, i10.busy, i10.done, i10.overflow}
                 : {i4.sgn_aux,  i4.full_aux,  i4.busy,  i4.done,  i4.overflow};
   endfunction

   task automatic set_in(input bit big, input logic dv, input logic [3:0] d,
                         input logic ov, input logic [1:0] o);
      if (big) begin
         i10.digit_valid = dv; i10.digit = d; i10.op_valid = ov; i10.op = o;
      end else begin
         i4.digit_valid = dv;  i4.digit = d;  i4.op_valid = ov;  i4.op = o;
      end
   endtask

   task automatic key(input bit big, input logic [3:0] d);
      set_in(big, 1'b1, d, 1'b0, 2'b00);
      tick();
      set_in(big, 1'b0, 4'h0, 1'b0, 2'b00);
   endtask

   task automatic key_op(input bit big, input logic [1:0] o);
      set_in(big, 1'b0, 4'h0, 1'b1, o);
      tick();
      set_in(big, 1'b0, 4'h0, 1'b0, 2'b00);
   endtask

   task automatic pulse_clear();
      i4.clear = 1'b1;
      tick();
      i4.clear = 1'b0;
   endtask

   // Key an op that must calculate; check done arrives, busy length, and done is one cycle.
   task automatic run_op(input bit big, input logic [1:0] o, input int exp_busy, input string tag);
      int nb;
      bit got;
      nb  = 0;
      got = 1'b0;
      key_op(big, o);
      for (int i = 0; i < 60; i++) begin
         if ((big ? i10.done : i4.done) === 1'b1) begin
            got = 1'b1;
            break;
         end
         if ((big ? i10.busy : i4.busy) === 1'b1) nb++;
         tick();
      end
      check({tag, "_done"}, 64'(got), 64'd1);
      check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
      tick();
      check({tag, "_done_pulse"}, 64'(big ? i10.done : i4.done), 64'd0);
   endtask

   initial begin
      int nd;
      rst = 1'b1;
      i4.clear = 1'b0;
      i10.clear = 1'b0;
      set_in(1'b0, 1'b0, 4'h0, 1'b0, 2'b00);
      set_in(1'b1, 1'b0, 4'h0, 1'b0, 2'b00);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_aux", aux_of(0), 64'h0);
      check("reset_status", 64'(status_of(0)), 64'h0);

      // 123 + 45 =
      key(0, 4'd1); key(0, 4'd2); key(0, 4'd3);
      check("t1_entry", aux_of(0), 64'h0123);
      run_op(0, 2'b01, 4, "t1_plus");
      check("t1_after_plus", aux_of(0), 64'h0123);
      key(0, 4'd4); key(0, 4'd5);
      check("t1_entry2", aux_of(0), 64'h0045);
      run_op(0, 2'b11, 4, "t1_eq");
      check("t1_result", aux_of(0), 64'h0168);
      check("t1_status", 64'(status_of(0)), 64'h0);

      // 15 - 40 = -25, then - 5 = -30, then + 30 = 0 (sign forced positive)
      key(0, 4'd1); key(0, 4'd5);
      check("t2_entry", aux_of(0), 64'h0015);
      run_op(0, 2'b10, 4, "t2_minus");
      key(0, 4'd4); key(0, 4'd0);
      run_op(0, 2'b11, 8, "t2_eq_neg");
      check("t2_neg_result", aux_of(0), 64'h0025);
      check("t2_neg_sign", 64'(status_of(0)), 64'b10000);
      key_op(0, 2'b10);
      check("t2_pending_only", 64'(status_of(0)), 64'b10000);
      key(0, 4'd5);
      run_op(0, 2'b11, 4, "t2_eq_chain");
      check("t2_chain_result", aux_of(0), 64'h0030);
      check("t2_chain_sign", 64'(status_of(0)), 64'b10000);
      key_op(0, 2'b01);
      key(0, 4'd3); key(0, 4'd0);
      run_op(0, 2'b11, 4, "t2_eq_zero");
      check("t2_zero_result", aux_of(0), 64'h0000);
      check("t2_zero_sign", 64'(status_of(0)), 64'b00000);

      // Entry limits and illegal digit
      pulse_clear();
      key(0, 4'd1); key(0, 4'd2); key(0, 4'hB); key(0, 4'd3);
      check("t4_bad_digit", aux_of(0), 64'h0123);
      check("t4_not_full", 64'(status_of(0)), 64'b00000);
      key(0, 4'd4);
      check("t4_full_aux", aux_of(0), 64'h1234);
      check("t4_full_flag", 64'(status_of(0)), 64'b01000);
      key(0, 4'd5);
      check("t4_dropped", aux_of(0), 64'h1234);

      // Digit and op in the same cycle: digit wins
      pulse_clear();
      key(0, 4'd2);
      set_in(0, 1'b1, 4'd3, 1'b1, 2'b01);
      tick();
      set_in(0, 1'b0, 4'h0, 1'b0, 2'b00);
      check("same_cycle_aux", aux_of(0), 64'h0023);
      tick();
      check("same_cycle_idle", 64'(status_of(0)), 64'b00000);

      // 7 + then - (replaces pending), 3 = -> 4
      pulse_clear();
      key(0, 4'd7);
      run_op(0, 2'b01, 4, "t5_plus");
      key_op(0, 2'b10);
      key(0, 4'd3);
      check("t5_entry", aux_of(0), 64'h0003);
      run_op(0, 2'b11, 4, "t5_eq");
      check("t5_result", aux_of(0), 64'h0004);
      check("t5_status", 64'(status_of(0)), 64'b00000);

      // 9999 + 1 overflows and locks
      pulse_clear();
      key(0, 4'd9); key(0, 4'd9); key(0, 4'd9); key(0, 4'd9);
      run_op(0, 2'b01, 4, "t3_plus");
      check("t3_9999", aux_of(0), 64'h9999);
      key(0, 4'd1);
      run_op(0, 2'b11, 4, "t3_eq");
      check("t3_ovf_aux", aux_of(0), 64'h00EE);
      check("t3_ovf_status", 64'(status_of(0)), 64'b00001);
      key(0, 4'd5);
      check("t3_lock_digit", aux_of(0), 64'h00EE);
      key_op(0, 2'b01);
      check("t3_lock_op", 64'(status_of(0)), 64'b00001);
      pulse_clear();
      check("t3_clear_aux", aux_of(0), 64'h0);
      check("t3_clear_status", 64'(status_of(0)), 64'h0);

      // 10-digit instance: 123 + 45 =
      key(1, 4'd1); key(1, 4'd2); key(1, 4'd3);
      run_op(1, 2'b01, 10, "t6_plus");
      key(1, 4'd4); key(1, 4'd5);
      run_op(1, 2'b11, 10, "t6_eq");
      check("t6_result", aux_of(1), 64'h0000000168);

      // Reset two cycles into a calculation
      key(1, 4'd9);
      key_op(1, 2'b01);
      tick(); tick();
      rst = 1'b1;
      #1;
      check("t6_rst_busy", 64'(i10.busy), 64'd0);
      check("t6_rst_aux", aux_of(1), 64'h0);
      tick();
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i10.done === 1'b1) nd++;
      end
      check("t6_no_done", 64'(nd), 64'd0);
      check("t6_idle_status", 64'(status_of(1)), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
